// File: rtl/nvdla_csb_apb_master_if.sv
// Host request/response stream plus APB3 master signals for the CSB APB feeder.
// Latency: none; this only bundles the wires.
// Backpressure: req_ready/resp_ready carry the stream stall; pready stalls the APB side.
interface nvdla_csb_apb_master_if;
  // request stream from the host bridge
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // response stream back to the host bridge
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // APB3 side towards the APB-to-CSB bridge
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/nvdla_csb_apb_master.sv
// Converts a valid/ready register request into one APB3 transfer and returns a response.
// Latency: accept -> SETUP -> ACCESS (>=1 cycle) -> response valid; one transfer in flight.
// Backpressure: req_ready only in IDLE; response held until resp_ready; ACCESS bounded by timeout.
module nvdla_csb_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_DEAD
) (
  input  logic                         csb_clk,
  input  logic                         csb_rst,
  nvdla_csb_apb_master_if.master       bus
);

  // Counter is at least 11 bits so the default 1023-cycle limit fits comfortably.
  localparam int unsigned CNT_BITS =
    ($clog2(TIMEOUT_CYCLES + 1) > 11) ? $clog2(TIMEOUT_CYCLES + 1) : 11;
  localparam bit                  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_BITS-1:0] CNT_LAST   =
    TIMEOUT_EN ? CNT_BITS'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [31:0]         resp_rdata_q;
  logic                resp_err_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [31:0]         paddr_q;
  logic [31:0]         pwdata_q;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;

  // Transfer FSM: every output is a register updated alongside the state.
  always_ff @(posedge csb_clk) begin
    if (csb_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            // Bus fields only change here, so they hold steady between transfers.
            pwrite_q    <= bus.req_write;
            paddr_q     <= bus.req_addr;
            pwdata_q    <= bus.req_wdata;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= SETUP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            // Completion beats a timeout landing on the same edge.
            resp_rdata_q <= pwrite_q ? 32'h0 : bus.prdata;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
            resp_rdata_q <= ERR_RDATA;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end else if (cnt_q != {CNT_BITS{1'b1}}) begin
            // Saturate so an unbounded wait cannot wrap the counter.
            cnt_q <= cnt_q + CNT_BITS'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvdla_csb_apb_master.sv
// Directed bench for the CSB APB master: latency, waits, timeout, backpressure, reset, random mix.
// Runs with TIMEOUT_CYCLES=4 so the timeout boundary is reachable in a few cycles.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_nvdla_csb_apb_master;
  localparam int unsigned TO = 4;

  logic csb_clk = 1'b0;
  logic csb_rst;
  int   total = 0;
  int   bad   = 0;

  nvdla_csb_apb_master_if bus ();

  nvdla_csb_apb_master #(
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (32'hDEAD_DEAD)
  ) dut (
    .csb_clk (csb_clk),
    .csb_rst (csb_rst),
    .bus     (bus)
  );

  always #5 csb_clk = ~csb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge csb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] slave_mem [16];
  logic [31:0] exp_mem   [16];

  // One complete transfer with a simple APB slave; waits = ACCESS cycles before pready.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int waits, output logic [31:0] rd, output logic er);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("xfer_accept_bound", 32'(n < 50), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("xfer_paddr", bus.paddr, a);
    chk("xfer_pwrite", 32'(bus.pwrite), 32'(w));
    if (w) chk("xfer_pwdata", bus.pwdata, d);
    tick();
    for (int i = 0; i < waits; i++) tick();
    bus.pready = 1'b1;
    bus.prdata = w ? 32'hFFFF_FFFF : slave_mem[a[5:2]];
    tick();
    if (w) slave_mem[a[5:2]] = d;
    bus.pready = 1'b0;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("xfer_resp_bound", 32'(n < 20), 32'd1);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;

    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      exp_mem[i]   = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    end

    csb_rst        = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus.prdata     = '0;
    bus.pready     = 1'b0;
    tick();
    tick();

    // reset values
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
    chk("rst_paddr", bus.paddr, 32'h0);
    chk("rst_pwdata", bus.pwdata, 32'h0);

    csb_rst = 1'b0;
    tick();
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // Read, pready in first ACCESS cycle; pready raised early during SETUP must be ignored.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_5004;
    bus.req_wdata = 32'hFFFF_FFFF;
    tick();
    bus.req_valid = 1'b0;
    chk("rd_setup_psel", 32'(bus.psel), 32'd1);
    chk("rd_setup_penable", 32'(bus.penable), 32'd0);
    chk("rd_setup_paddr", bus.paddr, 32'h0000_5004);
    chk("rd_setup_pwrite", 32'(bus.pwrite), 32'd0);
    chk("rd_setup_req_ready", 32'(bus.req_ready), 32'd0);
    bus.pready = 1'b1;
    bus.prdata = 32'h1234_5678;
    tick();
    chk("rd_access_psel", 32'(bus.psel), 32'd1);
    chk("rd_access_penable", 32'(bus.penable), 32'd1);
    chk("rd_access_resp_valid", 32'(bus.resp_valid), 32'd0);
    tick();
    bus.pready = 1'b0;
    bus.prdata = 32'h0;
    chk("rd_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("rd_resp_rdata", bus.resp_rdata, 32'h1234_5678);
    chk("rd_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rd_resp_psel", 32'(bus.psel), 32'd0);
    chk("rd_resp_paddr_hold", bus.paddr, 32'h0000_5004);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("rd_done_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rd_done_req_ready", 32'(bus.req_ready), 32'd1);

    // Write with 3 wait cycles, then hold the response for 10 cycles with a pending request.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_A008;
    bus.req_wdata = 32'hCAFE_0001;
    tick();
    bus.req_valid = 1'b0;
    chk("wr_setup_pwrite", 32'(bus.pwrite), 32'd1);
    chk("wr_setup_pwdata", bus.pwdata, 32'hCAFE_0001);
    chk("wr_setup_paddr", bus.paddr, 32'h0000_A008);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("wr_wait_penable", 32'(bus.penable), 32'd1);
      chk("wr_wait_pwrite", 32'(bus.pwrite), 32'd1);
      chk("wr_wait_req_ready", 32'(bus.req_ready), 32'd0);
      chk("wr_wait_resp_valid", 32'(bus.resp_valid), 32'd0);
      tick();
    end
    bus.pready = 1'b1;
    bus.prdata = 32'h5555_5555;
    tick();
    bus.pready = 1'b0;
    chk("wr_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("wr_resp_rdata", bus.resp_rdata, 32'h0);
    chk("wr_resp_err", 32'(bus.resp_err), 32'd0);
    chk("wr_resp_pwrite_hold", 32'(bus.pwrite), 32'd1);

    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_resp_rdata", bus.resp_rdata, 32'h0);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_psel", 32'(bus.psel), 32'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("bp_release_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_next_psel", 32'(bus.psel), 32'd1);
    chk("bp_next_paddr", bus.paddr, 32'h0000_0100);

    // The accepted read now times out: exactly 4 ACCESS cycles with pready stuck low.
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_access_penable", 32'(bus.penable), 32'd1);
      chk("to_access_resp_valid", 32'(bus.resp_valid), 32'd0);
      tick();
    end
    chk("to_psel", 32'(bus.psel), 32'd0);
    chk("to_penable", 32'(bus.penable), 32'd0);
    chk("to_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("to_resp_err", 32'(bus.resp_err), 32'd1);
    chk("to_resp_rdata", bus.resp_rdata, 32'hDEAD_DEAD);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;

    // pready arriving in the 4th ACCESS cycle completes normally.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0200;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("to_edge_penable", 32'(bus.penable), 32'd1);
    bus.pready = 1'b1;
    bus.prdata = 32'h0BAD_F00D;
    tick();
    bus.pready = 1'b0;
    chk("to_edge_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("to_edge_resp_err", 32'(bus.resp_err), 32'd0);
    chk("to_edge_resp_rdata", bus.resp_rdata, 32'h0BAD_F00D);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;

    // Reset during ACCESS discards the transfer.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0300;
    bus.req_wdata = 32'h7777_8888;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("mid_rst_in_access", 32'(bus.penable), 32'd1);
    csb_rst = 1'b1;
    tick();
    csb_rst    = 1'b0;
    bus.pready = 1'b1;
    chk("mid_rst_psel", 32'(bus.psel), 32'd0);
    chk("mid_rst_penable", 32'(bus.penable), 32'd0);
    chk("mid_rst_pwrite", 32'(bus.pwrite), 32'd0);
    chk("mid_rst_paddr", bus.paddr, 32'h0);
    chk("mid_rst_pwdata", bus.pwdata, 32'h0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
      chk("post_rst_no_psel", 32'(bus.psel), 32'd0);
    end
    bus.pready = 1'b0;

    // Back-to-back random mix against the slave model.
    for (int k = 0; k < 8; k++) begin
      w = 1'($urandom_range(0, 1));
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      xfer(w, a, d, int'($urandom_range(0, 3)), rd, er);
      chk("mix_err", 32'(er), 32'd0);
      if (w) begin
        chk("mix_wr_rdata", rd, 32'h0);
        exp_mem[a[5:2]] = d;
      end else begin
        chk("mix_rd_rdata", rd, exp_mem[a[5:2]]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
